rom_fetch_unit: RTL and testbench

//  Instruction-fetch front end between the processor decoder and the 256x8 program ROM.
//  - Owns the program counter and drives the ROM address.
//  - Absorbs the ROM's one-cycle synchronous read latency.
//  - Buffers prefetched bytes in a small FIFO.
//  - Hands bytes to the decoder on a valid/ready handshake.
//  - Supports PC redirect (jump/branch) with flush of stale fetches.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/rom_fetch_unit.sv | 124 ++++++++++++
 tb/tb_rom_fetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the ROM instruction-fetch front end.
// Pure declarations; no timing.
// No flow control of its own.
package fetch_pkg;

    // Width of a program ROM address; the fetch entry packs an address of this width.
    localparam int FETCH_ADDR_W = 8;

    // PC value loaded when RESET is asserted, unless overridden at the top.
    localparam logic [FETCH_ADDR_W-1:0] DEF_RESET_VECTOR = 8'h00;

    // Cycles between presenting ROM_ADDR and ROM_DATA being valid.
    localparam int ROM_LATENCY = 1;

    // One prefetched byte together with the ROM address it came from.
    typedef struct packed {
        logic [7:0]              data;
        logic [FETCH_ADDR_W-1:0] addr;
    } fetch_entry_t;

    // Occupancy counter width for a FIFO holding up to 'depth' entries.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push, pop and flush.
// Push visible at head the cycle after the write edge; pop takes effect at the edge.
// No internal backpressure: the producer must not push when full unless popping.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  fetch_entry_t                push_entry,
    input  logic                        pop,
    input  logic                        flush,
    output fetch_entry_t                head,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Popping an empty FIFO is ignored rather than corrupting the count.
    assign do_pop  = pop & ~empty;
    assign do_push = push;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    // Storage write; contents need no reset because the head is only used when not empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the 256x8 ROM, prefetches into a FIFO.
// Reset/redirect to first valid byte: 2 cycles (3 after a redirect cycle); 1 byte/cycle sustained.
// Issues a ROM read only when the FIFO plus the in-flight read still fit after this cycle's pop.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the STALL_CNT output, which counts
// cycles where the decoder was ready but no byte was valid (saturating at 16'hFFFF).
// ADDR_W must equal fetch_pkg::FETCH_ADDR_W, since FIFO entries carry an address of that width.
module rom_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W       = FETCH_ADDR_W,
    parameter int                DEPTH        = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [7:0]        ROM_DATA,
    output logic [7:0]        INSTR_DATA,
    output logic [ADDR_W-1:0] INSTR_ADDR,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       STALL_CNT
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OCC_W = CNT_W + 1;

    // The PC register doubles as the registered ROM address.
    logic [ADDR_W-1:0] pc;
    // A read was issued last cycle and its data is on ROM_DATA now.
    logic              inflight;
    // That read was issued during a redirect cycle and must be dropped.
    logic              kill;
    logic [ADDR_W-1:0] inflight_addr;

    logic              live_ret;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occ;
    fetch_entry_t      ret_entry;
    fetch_entry_t      fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign ROM_ADDR = pc;
    assign live_ret = inflight & ~kill;
    assign pop      = INSTR_VALID & INSTR_READY;
    // A return landing in a redirect cycle belongs to the old stream and is discarded.
    assign push     = live_ret & ~REDIRECT;

    // Slots committed at the end of this cycle; pop implies count>=1, so no underflow.
    assign occ   = OCC_W'(fifo_count) + OCC_W'(live_ret) - OCC_W'(pop);
    assign issue = (occ < OCC_W'(DEPTH));

    assign ret_entry = '{data: ROM_DATA, addr: inflight_addr};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RESET),
        .push       (push),
        .push_entry (ret_entry),
        .pop        (pop),
        .flush      (REDIRECT),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Outputs read as zero whenever nothing is buffered, so stale entries never leak out.
    assign INSTR_VALID = ~fifo_empty;
    assign INSTR_DATA  = INSTR_VALID ? fifo_head.data : 8'h00;
    assign INSTR_ADDR  = INSTR_VALID ? fifo_head.addr : '0;

    // PC advance, in-flight tracking and redirect kill; redirect overrides sequential advance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc            <= RESET_VECTOR;
            inflight      <= 1'b0;
            kill          <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            kill     <= REDIRECT;
            if (issue) inflight_addr <= pc;
            if (REDIRECT)   pc <= REDIRECT_ADDR;
            else if (issue) pc <= pc + ADDR_W'(1);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;

    // Count decoder-starved cycles; saturates instead of wrapping, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= 16'h0000;
        end else if (INSTR_READY && !INSTR_VALID && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = stall_cnt;
`endif

    // The occupancy check in the issue logic makes an overflowing push impossible.
    a_no_push_full: assert property (@(posedge CLK) disable iff (RESET)
        !(push && fifo_full && !pop));

    // Every request issued outside a redirect is tracked as live when its data returns.
    a_issue_tracked: assert property (@(posedge CLK) disable iff (RESET)
        (issue && !REDIRECT) |-> ##ROM_LATENCY (inflight && !kill));

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: registered ROM model, queue-based reference model, directed scenarios
// followed by randomized ready/redirect/reset traffic.
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
module tb_rom_fetch_unit;

    localparam int         ADDR_W = 8;
    localparam int         DEPTH  = 2;
    localparam logic [7:0] RV     = 8'h00;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ROM_ADDR;
    logic [7:0] ROM_DATA;
    logic [7:0] INSTR_DATA;
    logic [7:0] INSTR_ADDR;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic       REDIRECT;
    logic [7:0] REDIRECT_ADDR;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] STALL_CNT;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] rom [256];

    // Hand-computed expectations for the first bytes after reset (ROM[i] = i ^ A5).
    logic [7:0] s1_data [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
    logic [7:0] s1_addr [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0] wr_data [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    logic [7:0] wr_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    always #5 CLK = ~CLK;

    // One-cycle synchronous ROM.
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    rom_fetch_unit #(
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ROM_ADDR      (ROM_ADDR),
        .ROM_DATA      (ROM_DATA),
        .INSTR_DATA    (INSTR_DATA),
        .INSTR_ADDR    (INSTR_ADDR),
        .INSTR_VALID   (INSTR_VALID),
        .INSTR_READY   (INSTR_READY),
        .REDIRECT      (REDIRECT),
        .REDIRECT_ADDR (REDIRECT_ADDR)
`ifdef FETCH_PERF_CNT_EN
        ,
        .STALL_CNT     (STALL_CNT)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, then advance to the next falling edge.
    task automatic cyc(input bit rst, input bit rdy, input bit rd, input logic [7:0] ra);
        RESET         = rst;
        INSTR_READY   = rdy;
        REDIRECT      = rd;
        REDIRECT_ADDR = ra;
        @(negedge CLK);
    endtask

    // ---------------- reference model ----------------
    // FIFO contents as a queue of addresses (data is addr ^ A5), one pending read, the PC.
    logic [7:0]  mq [$];
    bit          m_pend;
    logic [7:0]  m_pend_addr;
    logic [7:0]  m_pc;
    bit          m_live = 1'b0;
    logic [15:0] m_stall;
    bit          m_pop;
    bit          m_issue;
    int          m_occ;

    // Advance the model on each rising edge, then compare the DUT against it.
    always @(posedge CLK) begin
        if (RESET) begin
            mq.delete();
            m_pend  = 1'b0;
            m_pc    = RV;
            m_stall = 16'h0000;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_pop = (mq.size() != 0) && INSTR_READY;
            if (INSTR_READY && mq.size() == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (REDIRECT) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = REDIRECT_ADDR;
            end else begin
                m_occ   = mq.size() + int'(m_pend) - int'(m_pop);
                m_issue = (m_occ < DEPTH);
                if (m_pop)  void'(mq.pop_front());
                if (m_pend) mq.push_back(m_pend_addr);
                m_pend      = m_issue;
                m_pend_addr = m_pc;
                if (m_issue) m_pc = m_pc + 8'd1;
            end
        end
        #1;
        if (m_live) begin
            chk("m_rom_addr", ROM_ADDR, m_pc);
            chk("m_valid", INSTR_VALID, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_data", INSTR_DATA, mq[0] ^ 8'hA5);
                chk("m_addr", INSTR_ADDR, mq[0]);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("m_stall_cnt", STALL_CNT, m_stall);
`endif
        end
    end

    // Entered in the reset-state cycle; releases reset and checks the first four bytes.
    task automatic run_from_reset(input string tag);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) chk({tag, "_rom_addr0"}, ROM_ADDR, RV);
            if (c < 2) begin
                chk({tag, "_bubble_valid"}, INSTR_VALID, 1'b0);
            end else begin
                chk({tag, "_valid"}, INSTR_VALID, 1'b1);
                chk({tag, "_data"}, INSTR_DATA, s1_data[c-2]);
                chk({tag, "_addr"}, INSTR_ADDR, s1_addr[c-2]);
            end
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bit rdy;
        bit rd;
        bit rst;
        logic [7:0] ra;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        RESET = 1'b1; INSTR_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_ADDR = 8'h00;
        @(negedge CLK);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset state.
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_rom_addr", ROM_ADDR, RV);
        chk("rst_data", INSTR_DATA, 8'h00);
        chk("rst_addr", INSTR_ADDR, 8'h00);

        // Reset release with the decoder always ready.
        run_from_reset("s1");

        // Decoder stalls for 5 cycles starting with the first valid byte.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 10; c++) begin
            if (c >= 2 && c < 7) begin
                chk("s2_hold_data", INSTR_DATA, 8'hA5);
                chk("s2_hold_valid", INSTR_VALID, 1'b1);
                chk("s2_rom_addr_stop", ROM_ADDR, 8'h02);
            end
            if (c == 8) chk("s2_after_addr1", INSTR_ADDR, 8'h01);
            if (c == 9) begin
                chk("s2_after_addr2", INSTR_ADDR, 8'h02);
                chk("s2_after_data2", INSTR_DATA, 8'hA7);
            end
            cyc(1'b0, !(c >= 2 && c < 7), 1'b0, 8'h00);
        end

        // Redirect to 40 with a full FIFO, then redirect to FE mid-stream (address wrap).
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) chk("s3_rom_addr", ROM_ADDR, 8'h40);
            if (c == 5 || c == 6) chk("s3_no_old", INSTR_VALID, 1'b0);
            if (c == 7) begin
                chk("s3_addr", INSTR_ADDR, 8'h40);
                chk("s3_data", INSTR_DATA, 8'hE5);
            end
            if (c == 8) chk("s3_data_next", INSTR_DATA, 8'hE4);
            if (c == 13) chk("s4_rom_addr", ROM_ADDR, 8'hFE);
            if (c == 13 || c == 14) chk("s4_no_old", INSTR_VALID, 1'b0);
            if (c >= 15 && c < 19) begin
                chk("s4_valid", INSTR_VALID, 1'b1);
                chk("s4_addr", INSTR_ADDR, wr_addr[c-15]);
                chk("s4_data", INSTR_DATA, wr_data[c-15]);
            end
            cyc(1'b0, !(c >= 2 && c < 4), (c == 4) || (c == 12), (c == 4) ? 8'h40 : 8'hFE);
        end

        // Reset mid-stream while two bytes are held.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) cyc(1'b0, c < 2, 1'b0, 8'h00);
        chk("s5_full_before", INSTR_VALID, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("s5_valid_after_rst", INSTR_VALID, 1'b0);
        chk("s5_rom_addr_after_rst", ROM_ADDR, RV);
        run_from_reset("s5");

`ifdef FETCH_PERF_CNT_EN
        // Two bubble cycles after reset plus two after a single redirect.
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("perf_reset", STALL_CNT, 16'd0);
        for (int c = 0; c < 10; c++) cyc(1'b0, 1'b1, c == 5, 8'h80);
        chk("perf_stall_cnt", STALL_CNT, 16'd4);
`endif

        // Randomized traffic, checked every cycle by the model.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(9, 0) < 7);
            rd  = ($urandom_range(19, 0) == 0);
            rst = ($urandom_range(199, 0) == 0);
            ra  = 8'($urandom);
            cyc(rst, rdy, rd, ra);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
